// File: rtl/cam_iic_pkg.sv
// Shared types and default timing for the camera I2C arbiter.
// Timing defaults assume a 100 MHz clock.
package cam_iic_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  localparam int BUS_FREE_DEF = 500;
  localparam int TIMEOUT_DEF  = 2500000;

endpackage

// File: rtl/cam_iic_arbiter_rr_pick.sv
// Round-robin selector: first eligible index at or after ptr,
// wrapping around the requester vector.
module rr_pick
  import cam_iic_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    elig,
  input  logic [ID_W-1:0] ptr,
  output logic            valid,
  output logic [ID_W-1:0] idx
);

  // scan from the pointer; first hit wins
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (!valid && elig[(int'(ptr) + i) % N]) begin
        valid = 1'b1;
        idx   = ID_W'((int'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/cam_iic_arbiter.sv
// Shares one I2C master port between NUM_REQ config engines:
// round-robin grant, bus-free gap, hung-grant timeout.
module cam_iic_arbiter
  import cam_iic_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int BUS_FREE_CYCLES = BUS_FREE_DEF,
  parameter int TIMEOUT_CYCLES  = TIMEOUT_DEF,
  localparam int ID_W           = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  input  logic [NUM_REQ-1:0] m_scl_o,
  input  logic [NUM_REQ-1:0] m_scl_t,
  input  logic [NUM_REQ-1:0] m_sda_o,
  input  logic [NUM_REQ-1:0] m_sda_t,
  output logic               m_scl_i,
  output logic               m_sda_i,
  input  logic               iic_scl_i,
  output logic               iic_scl_o,
  output logic               iic_scl_t,
  input  logic               iic_sda_i,
  output logic               iic_sda_o,
  output logic               iic_sda_t,
  output logic [ID_W-1:0]    active_id,
  output logic               timeout_flag,
  input  logic               timeout_clr
);

  localparam int FREE_W = $clog2(BUS_FREE_CYCLES + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] lock_q, lock_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [FREE_W-1:0]  free_q, free_d;
  logic               flag_q, flag_d;
  logic               set_flag;
  logic               bus_free;
  logic               pick_vld;
  logic [ID_W-1:0]    pick_idx;

  assign bus_free = free_q >= FREE_W'(BUS_FREE_CYCLES);

  rr_pick #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_pick (
    .elig  (req & ~lock_q),
    .ptr   (ptr_q),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  // next-state: grant FSM, lockout, timeout flag, bus-free counter
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    id_d     = id_q;
    ptr_d    = ptr_q;
    tmo_d    = tmo_q;
    lock_d   = lock_q & req;
    set_flag = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus_free && pick_vld) begin
          gnt_d   = NUM_REQ'(1) << pick_idx;
          id_d    = pick_idx;
          ptr_d   = (pick_idx == ID_W'(NUM_REQ - 1)) ?
                    '0 : pick_idx + ID_W'(1);
          tmo_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (!req[id_q]) begin
          gnt_d   = '0;
          id_d    = '0;
          state_d = RELEASE;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          gnt_d        = '0;
          id_d         = '0;
          lock_d[id_q] = 1'b1;
          set_flag     = 1'b1;
          state_d      = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    flag_d = set_flag ? 1'b1 : (timeout_clr ? 1'b0 : flag_q);

    if (state_q == GRANT && state_d == RELEASE)
      free_d = '0;
    else if (!(iic_scl_i && iic_sda_i))
      free_d = '0;
    else if (!bus_free)
      free_d = free_q + FREE_W'(1);
    else
      free_d = free_q;
  end

  // state registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      lock_q  <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      tmo_q   <= '0;
      free_q  <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      lock_q  <= lock_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      tmo_q   <= tmo_d;
      free_q  <= free_d;
      flag_q  <= flag_d;
    end
  end

  // bus mux from the registered grant; released when idle
  always_comb begin
    iic_scl_o = 1'b1;
    iic_scl_t = 1'b1;
    iic_sda_o = 1'b1;
    iic_sda_t = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_q[i]) begin
        iic_scl_o = m_scl_o[i];
        iic_scl_t = m_scl_t[i];
        iic_sda_o = m_sda_o[i];
        iic_sda_t = m_sda_t[i];
      end
    end
  end

  assign gnt          = gnt_q;
  assign active_id    = id_q;
  assign timeout_flag = flag_q;
  assign m_scl_i      = iic_scl_i;
  assign m_sda_i      = iic_sda_i;

endmodule

// File: tb/tb_cam_iic_arbiter.sv
// Directed scoreboard bench for cam_iic_arbiter
// (BUS_FREE_CYCLES=4, TIMEOUT_CYCLES=64, pulled-up bus).
module tb_cam_iic_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] gnt;
  logic [3:0] m_scl_o = '1;
  logic [3:0] m_scl_t = '1;
  logic [3:0] m_sda_o = '1;
  logic [3:0] m_sda_t = '1;
  logic       m_scl_i, m_sda_i;
  logic       iic_scl_i, iic_scl_o, iic_scl_t;
  logic       iic_sda_i, iic_sda_o, iic_sda_t;
  logic [1:0] active_id;
  logic       timeout_flag;
  logic       timeout_clr = 1'b0;
  logic       sda_force = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  string       tq[$];
  logic [31:0] vq[$];

  always #5 clk = ~clk;

  assign iic_scl_i = iic_scl_t | iic_scl_o;
  assign iic_sda_i = (iic_sda_t | iic_sda_o) & ~sda_force;

  cam_iic_arbiter #(
    .NUM_REQ         (4),
    .BUS_FREE_CYCLES (4),
    .TIMEOUT_CYCLES  (64)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .gnt          (gnt),
    .m_scl_o      (m_scl_o),
    .m_scl_t      (m_scl_t),
    .m_sda_o      (m_sda_o),
    .m_sda_t      (m_sda_t),
    .m_scl_i      (m_scl_i),
    .m_sda_i      (m_sda_i),
    .iic_scl_i    (iic_scl_i),
    .iic_scl_o    (iic_scl_o),
    .iic_scl_t    (iic_scl_t),
    .iic_sda_i    (iic_sda_i),
    .iic_sda_o    (iic_sda_o),
    .iic_sda_t    (iic_sda_t),
    .active_id    (active_id),
    .timeout_flag (timeout_flag),
    .timeout_clr  (timeout_clr)
  );

  task automatic push(input string tag, input logic [31:0] v);
    tq.push_back(tag);
    vq.push_back(v);
  endtask

  task automatic chk(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    n_cmp++;
    if (vq.size() == 0) begin
      n_err++;
      $error("FAIL sb_empty observed=%0h", obs);
    end else begin
      t = tq.pop_front();
      e = vq.pop_front();
      assert (obs === e) else begin
        n_err++;
        $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // negedges until a grant shows; bound+1 when none arrives
  task automatic wait_gnt(input int bound, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (gnt == '0 && cyc <= bound);
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    req         = '0;
    sda_force   = 1'b0;
    timeout_clr = 1'b0;
    m_scl_o = '1; m_scl_t = '1;
    m_sda_o = '1; m_sda_t = '1;
    tick(2);
    reset = 1'b0;
    tick(8);
  endtask

  initial begin
    int c;
    int g;
    int k;

    // reset state
    @(negedge clk);
    push("rst_gnt", 0);   chk(32'(gnt));
    push("rst_id", 0);    chk(32'(active_id));
    push("rst_flag", 0);  chk(32'(timeout_flag));
    push("rst_scl_t", 1); chk(32'(iic_scl_t));
    push("rst_sda_o", 1); chk(32'(iic_sda_o));
    do_reset();

    // 1: single grant, mux, release gap
    req = 4'b0001;
    push("t1_lat", 1);
    wait_gnt(20, c); chk(32'(c));
    push("t1_gnt", 1); chk(32'(gnt));
    m_scl_t[0] = 1'b0; m_scl_o[0] = 1'b0;
    #1;
    push("t1_scl_t", 0); chk(32'(iic_scl_t));
    push("t1_m_scl_i", 0); chk(32'(m_scl_i));
    m_scl_t[0] = 1'b1; m_scl_o[0] = 1'b1;
    tick(2);
    req = 4'b0000;
    tick(1);
    push("t1_drop", 0); chk(32'(gnt));
    req = 4'b0001;
    push("t1_regrant_wait", 5);
    wait_gnt(20, c); chk(32'(c));

    // 2: round robin with all requesting
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      k = i % 4;
      push("t2_wait", (i == 0) ? 1 : 5);
      wait_gnt(20, c); chk(32'(c));
      push("t2_gnt", 32'(1) << k); chk(32'(gnt));
      push("t2_id", 32'(k)); chk(32'(active_id));
      tick(10);
      req[k] = 1'b0;
      tick(1);
      push("t2_rel", 0); chk(32'(gnt));
      req[k] = 1'b1;
    end

    // 3: timeout, lockout, flag clear
    do_reset();
    req = 4'b0100;
    push("t3_lat", 1);
    wait_gnt(20, c); chk(32'(c));
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (gnt != '0 && c < 200);
    push("t3_len", 64); chk(32'(c));
    push("t3_flag", 1); chk(32'(timeout_flag));
    g = 0;
    repeat (35) begin
      @(negedge clk);
      if (gnt != '0) g++;
    end
    push("t3_locked", 0); chk(32'(g));
    req = 4'b0000;
    tick(1);
    req = 4'b0100;
    push("t3_unlock_lat", 1);
    wait_gnt(20, c); chk(32'(c));
    push("t3_regnt", 4); chk(32'(gnt));
    push("t3_flag_sticky", 1); chk(32'(timeout_flag));
    timeout_clr = 1'b1;
    tick(1);
    timeout_clr = 1'b0;
    push("t3_flag_clr", 0); chk(32'(timeout_flag));

    // 4: external SDA low delays next grant
    do_reset();
    req = 4'b0010;
    push("t4_lat", 1);
    wait_gnt(20, c); chk(32'(c));
    push("t4_gnt1", 2); chk(32'(gnt));
    tick(1);
    req = 4'b1000;
    sda_force = 1'b1;
    #1;
    push("t4_m_sda_i", 0); chk(32'(m_sda_i));
    g = 0;
    repeat (10) begin
      @(negedge clk);
      if (gnt != '0) g++;
    end
    sda_force = 1'b0;
    push("t4_held_off", 0); chk(32'(g));
    push("t4_wait", 5);
    wait_gnt(20, c); chk(32'(c));
    push("t4_gnt3", 8); chk(32'(gnt));

    // 5: reset during an active grant
    do_reset();
    req = 4'b0100;
    push("t5_lat", 1);
    wait_gnt(20, c); chk(32'(c));
    push("t5_id", 2); chk(32'(active_id));
    m_sda_t[2] = 1'b0; m_sda_o[2] = 1'b0;
    #1;
    push("t5_sda_t_drv", 0); chk(32'(iic_sda_t));
    reset = 1'b1;
    tick(1);
    push("t5_gnt", 0);   chk(32'(gnt));
    push("t5_sda_t", 1); chk(32'(iic_sda_t));
    push("t5_scl_t", 1); chk(32'(iic_scl_t));
    push("t5_id0", 0);   chk(32'(active_id));

    // 6: drop coincides with timeout
    do_reset();
    req = 4'b0001;
    push("t6_lat", 1);
    wait_gnt(20, c); chk(32'(c));
    tick(63);
    push("t6_still", 1); chk(32'(gnt));
    req = 4'b0000;
    tick(1);
    push("t6_gnt", 0);  chk(32'(gnt));
    push("t6_flag", 0); chk(32'(timeout_flag));
    req = 4'b0001;
    push("t6_nolock", 5);
    wait_gnt(20, c); chk(32'(c));
    push("t6_regnt", 1); chk(32'(gnt));

    req = '0;
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
